// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: write-op encoding and default sizes.
package reg_bank_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_CLR  = 2'd3
    } wr_op_e;

    // Defaults shared with the decode stage
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/reg_bank_if.sv
// Write/read port bundle of the register bank; master = decode side, slave = bank.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [OP_W-1:0]   wr_op;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              carry;
    logic              addr_err;

    modport master (
        output wr_en, wr_op, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, carry, addr_err
    );

    modport slave (
        input  wr_en, wr_op, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, carry, addr_err
    );
endinterface

// File: rtl/reg_bank_alu.sv
// Combinational op unit: computes the next register value and a wrap flag
// for LOAD / INC / DEC / CLR. Its result also feeds the read bypass path.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_val,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Op decode; wrap flags INC from all-ones and DEC from zero
    always_comb begin
        next_val = cur_val;
        wrap     = 1'b0;
        case (wr_op_e'(op))
            OP_LOAD: next_val = operand;
            OP_INC: begin
                next_val = cur_val + ONE;
                wrap     = &cur_val;
            end
            OP_DEC: begin
                next_val = cur_val - ONE;
                wrap     = ~|cur_val;
            end
            OP_CLR:  next_val = '0;
            default: next_val = cur_val;
        endcase
    end
endmodule

// File: rtl/reg_bank.sv
// Parametrised bank of DEPTH x WIDTH registers with one op write port and one
// registered read port. Optional macro REG_BANK_BYPASS_EN forwards the post-op
// value to a same-address same-cycle read; without it the read sees the
// pre-write value.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic       clk,
    input logic       rst_n,
    reg_bank_if.slave bus
);
    localparam int                ADDR_W  = $clog2(DEPTH);
    // One extra bit so the bound itself is representable for non-power-of-two depths
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_rd [DEPTH];
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_go;
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] rd_cur;
    logic [WIDTH-1:0] alu_next;
    logic             alu_wrap;

    logic [WIDTH-1:0] rd_data_d,  rd_data_q;
    logic             rd_valid_d, rd_valid_q;
    logic             carry_d,    carry_q;
    logic             addr_err_d, addr_err_q;

    // Range checks and operand selection; mux loops avoid out-of-bounds indexing
    always_comb begin
        wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_C);
        rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);
        wr_go       = bus.wr_en && wr_in_range;
        wr_cur      = '0;
        rd_cur      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.wr_addr == ADDR_W'(i)) wr_cur = mem_rd[i];
            if (bus.rd_addr == ADDR_W'(i)) rd_cur = mem_rd[i];
        end
    end

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .cur_val  (wr_cur),
        .op       (bus.wr_op),
        .operand  (bus.wr_data),
        .next_val (alu_next),
        .wrap     (alu_wrap)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_d, entry_q;

            // Only the addressed in-range entry takes the op result
            always_comb begin
                entry_d = entry_q;
                if (wr_go && (bus.wr_addr == ADDR_W'(gi))) entry_d = alu_next;
            end

            // Storage flop, cleared asynchronously
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) entry_q <= '0;
                else        entry_q <= entry_d;
            end

            assign mem_rd[gi] = entry_q;
        end
    endgenerate

    // Next values for the read port and status flags
    always_comb begin
        rd_valid_d = bus.rd_en && rd_in_range;
        rd_data_d  = '0;
        if (rd_valid_d) begin
            rd_data_d = rd_cur;
`ifdef REG_BANK_BYPASS_EN
            if (wr_go && (bus.wr_addr == bus.rd_addr)) rd_data_d = alu_next;
`endif
        end
        carry_d    = wr_go && alu_wrap;
        addr_err_d = (bus.wr_en && !wr_in_range) || (bus.rd_en && !rd_in_range);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            carry_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            carry_q    <= carry_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.carry    = carry_q;
    assign bus.addr_err = addr_err_q;
endmodule
